imem_fetch_ctrl: RTL

Instruction-fetch sequencer that drives the instruction memory on behalf of the core front-end. It generates word-aligned fetch addresses and issues read requests to a synchronous-read instruction memory with a fixed 1-cycle latency. Returned words are buffered with their PCs in a small prefetch FIFO, and handed to the decode stage over a valid/ready handshake. Branch/jump redirects flush all buffered and in-flight fetches.

---
 rtl/imem_fetch_pkg.sv | 21 ++
 rtl/imem_fetch_ctrl_fifo.sv | 61 ++++++
 rtl/imem_fetch_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fifo_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush overrides push and pop.
module fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  fifo_entry_t                   push_data,
    input  logic                          pop,
    output fifo_entry_t                   head,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           empty;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: issues word-aligned reads, buffers returns, hands them to decode.
// Optional performance counters are built only when IMEM_FETCH_PERF_EN is defined.
//
// state | meaning
// IDLE  | no new memory requests; buffered words still drain to decode
// RUN   | issue one request per cycle while prefetch space allows
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic           run;
    logic [31:0]    fetch_pc;
    logic [31:0]    last_addr;
    logic [31:0]    inflight_pc;
    logic           inflight;
    logic [CW-1:0]  fifo_count;
    logic [OW-1:0]  occupancy;
    logic           fifo_push;
    logic           fifo_pop;
    fifo_entry_t    fifo_wdata;
    fifo_entry_t    fifo_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_en)  state_nxt = RUN;
            RUN:     if (!fetch_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An in-flight word reserves its FIFO slot, so the memory latency can never overflow the buffer.
    assign occupancy = OW'(fifo_count) + OW'(inflight);

    always_comb begin
        run     = (state == RUN);
        mem_req = run && !redirect_valid && !reset && (occupancy < OW'(FIFO_DEPTH));
    end

    assign mem_addr = mem_req ? fetch_pc : last_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            last_addr   <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= mem_req;
            if (mem_req) begin
                inflight_pc <= fetch_pc;
                last_addr   <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
            end else if (mem_req) begin
                fetch_pc <= fetch_pc + INSTR_BYTES;
            end
        end
    end

    // A redirect kills the word returning this cycle and ignores any pop alongside it.
    assign fifo_push  = inflight && !redirect_valid;
    assign fifo_pop   = if_valid && if_ready && !redirect_valid;
    assign fifo_wdata = '{pc: inflight_pc, instr: mem_rdata};

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (fifo_push),
        .push_data  (fifo_wdata),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    assign if_valid = (fifo_count != '0);
    assign if_pc    = if_valid ? fifo_head.pc    : 32'h0;
    assign if_instr = if_valid ? fifo_head.instr : 32'h0;

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (mem_req) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (run && !if_valid) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule
